interval_timer: RTL and testbench
=================================

INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the width of PERIOD and COUNT.
REQ-002 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 RST_N  input  1  reset; asynchronous, active-low.
REQ-004 START  input  1  SHALL request a new timing run; sampled at the rising edge.
REQ-005 STOP  input  1  SHALL abort the current run.
REQ-006 PAUSE  input  1  SHALL freeze counting while high.
REQ-007 MODE  input  1  SHALL select the run type: 0 = one-shot, 1 = periodic; sampled with START.
REQ-008 PERIOD  input  WIDTH  SHALL give the terminal count N; sampled with START.
REQ-009 COUNT  output  WIDTH  current count value, registered.
REQ-010 BUSY  output  1  SHALL be high in RUN or HOLD.
REQ-011 PAUSED  output  1  SHALL be high in HOLD only.
REQ-012 TICK  output  1  registered one-cycle pulse on each terminal count.
REQ-013 DONE  output  1  registered one-cycle pulse when a one-shot run completes.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and HOLD.
REQ-015 START in IDLE with PERIOD != 0 SHALL latch PERIOD into PER and MODE into MD, set COUNT to 0, and enter RUN (or HOLD if PAUSE=1) at that edge.
REQ-016 START in IDLE with PERIOD == 0 SHALL be ignored: the block stays in IDLE and no output changes.
REQ-017 START in RUN or HOLD SHALL be ignored; PER and MD SHALL NOT change mid-run.
REQ-018 Count rule in RUN/HOLD: on each edge with PAUSE=0 and no STOP, COUNT SHALL increment by 1; with PAUSE=1, COUNT SHALL hold.
REQ-019 The state after any non-terminating RUN/HOLD edge SHALL be HOLD if PAUSE=1, else RUN.
REQ-020 Terminal event: on a counting edge with COUNT == PER-1, COUNT SHALL become 0 and TICK SHALL be 1 for the following cycle.
REQ-021 On a terminal event with MD=1, the block SHALL remain in RUN/HOLD per REQ-019 and continue counting from 0 with the same PER.
REQ-022 On a terminal event with MD=0, the block SHALL enter IDLE, drop BUSY, and assert DONE in the same cycle as TICK.
REQ-023 Latency: with START at edge k and PAUSE=0 throughout, COUNT SHALL equal j after edge k+j (j<N), and TICK SHALL be high in the cycle after edge k+N, then again after edges k+2N, k+3N, ... when periodic.
REQ-024 PER=1 periodic SHALL assert TICK every cycle from the cycle after edge k+1, with COUNT constantly 0.
REQ-025 STOP in RUN/HOLD SHALL take priority over the terminal event and PAUSE: the block SHALL enter IDLE with COUNT=0 and SHALL assert neither TICK nor DONE.
REQ-026 STOP and START together in IDLE: the block SHALL stay in IDLE.
REQ-027 COUNT SHALL hold its value in IDLE, except where REQ-015 and REQ-025 set it.
REQ-028 Arithmetic SHALL be unsigned modulo 2^WIDTH; PER = 2^WIDTH-1 SHALL count through every value 0..2^WIDTH-2.
REQ-029 TICK and DONE SHALL be low in every cycle not named in REQ-020 and REQ-022.

Reset
REQ-030 While RST_N=0, the block SHALL be in IDLE immediately, without waiting for a clock edge, with COUNT=0, PER=0, MD=0 and BUSY, PAUSED, TICK and DONE all 0.
REQ-031 RST_N falling mid-run SHALL abort the run with no TICK or DONE, and the block SHALL NOT resume after release.
REQ-032 After release, the first rising CLK edge SHALL be a normal functional edge; the block SHALL need a new START to run.

Verification
REQ-033 One-shot, PERIOD=5, START at edge k -> COUNT 0,1,2,3,4; TICK=DONE=1 only in the cycle after edge k+5; then BUSY=0 and COUNT=0.
REQ-034 Periodic, PERIOD=3 -> TICK after edges k+3, k+6 and k+9, DONE never asserted; PERIOD changed to 7 mid-run -> spacing stays 3.
REQ-035 Periodic, PERIOD=4, PAUSE high for 2 cycles when COUNT=2 -> PAUSED=1 and COUNT holds at 2 for 2 cycles; first TICK delayed by 2 cycles.
REQ-036 STOP on the same edge COUNT==PER-1 -> IDLE, COUNT=0, no TICK, no DONE.
REQ-037 Edge cases: START with PERIOD=0 -> remains IDLE; PERIOD=1 periodic -> TICK every cycle; START while BUSY -> ignored.
REQ-038 RST_N pulsed low between clock edges mid-run, COUNT=9 -> outputs clear before the next edge; no activity until a new START.

Source files
------------

// File: rtl/interval_timer.sv
// Programmable interval timer: one-shot or periodic runs of PERIOD counting cycles,
// with pause, abort and registered tick/done pulses.
module interval_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             mode,
   input  logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             paused,
   output logic             tick,
   output logic             done,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state;
   logic [WIDTH-1:0] per;
   logic             md;
   logic             start_ok;
   logic             at_term;

   // A start that arrives together with stop, or with a zero period, is dropped.
   assign start_ok  = start && !stop && (period != '0);
   assign at_term   = (count == per - ONE);
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         per    <= '0;
         md     <= 1'b0;
         count  <= '0;
         busy   <= 1'b0;
         paused <= 1'b0;
         tick   <= 1'b0;
         done   <= 1'b0;
      end else begin
         tick <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  per    <= period;
                  md     <= mode;
                  count  <= '0;
                  busy   <= 1'b1;
                  paused <= pause;
                  state  <= pause ? HOLD : RUN;
               end
            end
            RUN, HOLD: begin
               // Stop outranks both pause and the terminal event.
               if (stop) begin
                  state  <= IDLE;
                  count  <= '0;
                  busy   <= 1'b0;
                  paused <= 1'b0;
               end else if (pause) begin
                  state  <= HOLD;
                  paused <= 1'b1;
               end else if (at_term) begin
                  count  <= '0;
                  tick   <= 1'b1;
                  paused <= 1'b0;
                  if (md) begin
                     state <= RUN;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  count  <= count + ONE;
                  state  <= RUN;
                  paused <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               paused <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed scenarios plus random traffic,
// checked against an elapsed-cycle reference model.
module tb_interval_timer;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         stop;
   logic         pause;
   logic         mode;
   logic [W-1:0] period;
   logic [W-1:0] count;
   logic         busy;
   logic         paused;
   logic         tick;
   logic         done;
   logic [1:0]   fsm_state;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a run is described by how many counting edges have elapsed.
   logic         m_active;
   logic         m_hold;
   logic [W-1:0] m_per;
   logic         m_md;
   longint       m_elapsed;
   logic [W-1:0] m_count;
   logic         m_tick;
   logic         m_done;

   logic [W+3:0] got;
   logic [W+3:0] exp;

   interval_timer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .pause     (pause),
      .mode      (mode),
      .period    (period),
      .count     (count),
      .busy      (busy),
      .paused    (paused),
      .tick      (tick),
      .done      (done),
      .fsm_state (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_active  = 1'b0;
      m_hold    = 1'b0;
      m_per     = '0;
      m_md      = 1'b0;
      m_elapsed = 0;
      m_count   = '0;
      m_tick    = 1'b0;
      m_done    = 1'b0;
   endtask

   // Apply inputs, take one rising edge, advance the model, settle 1 ns past the edge.
   task automatic step(input logic s, input logic st, input logic p, input logic md,
                       input logic [W-1:0] per);
      start  = s;
      stop   = st;
      pause  = p;
      mode   = md;
      period = per;
      @(posedge clk);
      m_tick = 1'b0;
      m_done = 1'b0;
      if (!m_active) begin
         if (s && !st && per != 0) begin
            m_active  = 1'b1;
            m_hold    = p;
            m_per     = per;
            m_md      = md;
            m_elapsed = 0;
            m_count   = '0;
         end
      end else if (st) begin
         m_active = 1'b0;
         m_hold   = 1'b0;
         m_count  = '0;
      end else if (p) begin
         m_hold = 1'b1;
      end else begin
         m_hold    = 1'b0;
         m_elapsed = m_elapsed + 1;
         m_count   = W'(m_elapsed % longint'(m_per));
         if (m_elapsed % longint'(m_per) == 0) begin
            m_tick = 1'b1;
            if (!m_md) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end
      end
      #1;
      got = {count, busy, paused, tick, done};
      exp = {m_count, m_active, m_hold, m_tick, m_done};
   endtask

   task automatic test_reset();
      start = 0; stop = 0; pause = 0; mode = 0; period = '0;
      rst_n = 1'b0;
      model_reset();
      #3;
      n_cmp++;
      if ({count, busy, paused, tick, done} !== '0) begin
         n_bad++;
         $display("FAIL reset_async got=%h exp=0", {count, busy, paused, tick, done});
      end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({count, busy, paused, tick, done} !== '0) begin
         n_bad++;
         $display("FAIL reset_held got=%h exp=0", {count, busy, paused, tick, done});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_one_shot();
      int ticks = 0;
      int tick_at = -1;
      for (int c = 0; c < 10; c++) begin
         step(c == 0, 1'b0, 1'b0, 1'b0, 8'd5);
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL one_shot c=%0d got=%h exp=%h", c, got, exp);
         end
         if (tick) begin ticks++; tick_at = c; end
      end
      n_cmp++;
      if (ticks != 1 || tick_at != 5) begin
         n_bad++;
         $display("FAIL one_shot_tick_time got=%0d@%0d exp=1@5", ticks, tick_at);
      end
   endtask

   task automatic test_periodic();
      logic [31:0] mask = '0;
      for (int c = 0; c < 12; c++) begin
         // A second start with period 7 mid-run must not disturb the 3-cycle spacing.
         step(c == 0 || c == 4, c == 11, 1'b0, 1'b1, (c == 4) ? 8'd7 : 8'd3);
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL periodic c=%0d got=%h exp=%h", c, got, exp);
         end
         if (tick) mask[c] = 1'b1;
      end
      n_cmp++;
      if (mask !== 32'h0000_0248) begin
         n_bad++;
         $display("FAIL periodic_ticks got=%h exp=00000248", mask);
      end
   endtask

   task automatic test_pause();
      logic [31:0] mask = '0;
      for (int c = 0; c < 12; c++) begin
         step(c == 0, c == 11, c == 3 || c == 4, 1'b1, 8'd4);
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL pause c=%0d got=%h exp=%h", c, got, exp);
         end
         if (tick) mask[c] = 1'b1;
      end
      n_cmp++;
      if (mask !== 32'h0000_0440) begin
         n_bad++;
         $display("FAIL pause_ticks got=%h exp=00000440", mask);
      end
   endtask

   task automatic test_stop_terminal();
      logic [31:0] mask = '0;
      for (int c = 0; c < 7; c++) begin
         step(c == 0, c == 4, 1'b0, 1'b0, 8'd4);
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL stop_terminal c=%0d got=%h exp=%h", c, got, exp);
         end
         if (tick || done) mask[c] = 1'b1;
      end
      n_cmp++;
      if (mask !== '0) begin
         n_bad++;
         $display("FAIL stop_terminal_pulses got=%h exp=0", mask);
      end
   endtask

   task automatic test_edges();
      logic [31:0] mask = '0;
      for (int c = 0; c < 11; c++) begin
         case (c)
            0:       step(1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
            2:       step(1'b1, 1'b1, 1'b0, 1'b1, 8'd3);
            3:       step(1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
            6:       step(1'b1, 1'b0, 1'b0, 1'b0, 8'd9);
            9:       step(1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
            default: step(1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
         endcase
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL edges c=%0d got=%h exp=%h", c, got, exp);
         end
         if (tick) mask[c] = 1'b1;
      end
      n_cmp++;
      if (mask !== 32'h0000_01f0) begin
         n_bad++;
         $display("FAIL edges_per1_ticks got=%h exp=000001f0", mask);
      end
   endtask

   task automatic test_async_reset();
      for (int c = 0; c < 10; c++) begin
         step(c == 0, 1'b0, 1'b0, 1'b0, 8'd20);
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL async_run c=%0d got=%h exp=%h", c, got, exp);
         end
      end
      n_cmp++;
      if (count !== 8'd9) begin
         n_bad++;
         $display("FAIL async_precount got=%0d exp=9", count);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({count, busy, paused, tick, done} !== '0) begin
         n_bad++;
         $display("FAIL async_clear got=%h exp=0", {count, busy, paused, tick, done});
      end
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 6; c++) begin
         step(1'b0, 1'b0, c[0], 1'b0, 8'd20);
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL async_after c=%0d got=%h exp=%h", c, got, exp);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0,
              $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
              W'($urandom_range(0, 6)));
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL random c=%0d got=%h exp=%h", c, got, exp);
         end
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL random_stop got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_full_range();
      int ticks = 0;
      int first = -1;
      logic [W-1:0] max_cnt = '0;
      for (int c = 0; c < 516; c++) begin
         step(c == 0, c == 515, 1'b0, 1'b1, 8'd255);
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL full_range c=%0d got=%h exp=%h", c, got, exp);
         end
         if (count > max_cnt) max_cnt = count;
         if (tick) begin
            ticks++;
            if (first < 0) first = c;
         end
      end
      n_cmp++;
      if (max_cnt !== 8'd254 || ticks != 2 || first != 255) begin
         n_bad++;
         $display("FAIL full_range_wrap got=max%0d/%0d@%0d exp=max254/2@255",
                  max_cnt, ticks, first);
      end
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_periodic();
      test_pause();
      test_stop_terminal();
      test_edges();
      test_async_reset();
      test_random();
      test_full_range();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
